mac_vec_sat: RTL and testbench

- Parametrised, pipelined, saturating multiply-accumulate engine; successor to the single-stream 14x14->28 saturating MAC.
- Accumulates signed a*b products over a vector, either VEC_LEN elements or fewer when terminated by last_in, and emits one saturated dot-product per vector.
- Uses a valid/ready handshake on both sides, so it can sit between a streaming operand source and a result consumer with backpressure.

---
 rtl/mac_pkg.sv | 50 +++++
 rtl/sat_accum.sv | 90 +++++++++
 rtl/mac_vec_sat.sv | 127 ++++++++++++
 tb/tb_mac_vec_sat.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and saturating-arithmetic helpers for the vector MAC.
package mac_pkg;

  // Widest accumulator the helpers support; arithmetic is done at this width and
  // clamped down to the caller's accumulator width.
  localparam int unsigned MaxW = 64;

  typedef logic signed [MaxW-1:0] wide_t;

  // Per-stage tag travelling alongside the operands.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Result of a saturating add: overflow flag plus the clamped value.
  typedef struct packed {
    logic  ovf;
    wide_t val;
  } sat_res_t;

  // Largest value representable in acc_w signed bits.
  function automatic wide_t acc_max(int unsigned acc_w);
    return (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
  endfunction

  // Smallest value representable in acc_w signed bits.
  function automatic wide_t acc_min(int unsigned acc_w);
    return -(wide_t'(1) <<< (acc_w - 1));
  endfunction

  // Adds two sign-extended operands that each fit in acc_w bits and clamps the sum
  // back into acc_w bits. The wide sum cannot wrap while acc_w < MaxW.
  function automatic sat_res_t sat_add(wide_t acc, wide_t addend, int unsigned acc_w);
    wide_t    sum;
    sat_res_t res;
    sum     = acc + addend;
    res.ovf = 1'b0;
    res.val = sum;
    if (sum > acc_max(acc_w)) begin
      res.ovf = 1'b1;
      res.val = acc_max(acc_w);
    end else if (sum < acc_min(acc_w)) begin
      res.ovf = 1'b1;
      res.val = acc_min(acc_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator with sticky overflow flag and a handshaked result register.
module sat_accum
  import mac_pkg::*;
#(
  parameter int unsigned AccW  = 28,
  parameter int unsigned ProdW = 28
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  tag_t                    in_tag_i,
  input  logic signed [ProdW-1:0] prod_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic signed [AccW-1:0]  f_o,
  output logic                    sat_o,
  output logic                    stall_o
);

  logic signed [AccW-1:0] acc_q, acc_d;
  logic signed [AccW-1:0] f_q, f_d;
  logic                   sat_acc_q, sat_acc_d;
  logic                   sat_q, sat_d;
  logic                   valid_q, valid_d;

  logic                   stall;
  logic                   step;
  logic                   out_fire;
  sat_res_t               res;
  logic signed [AccW-1:0] clamped;
  logic                   unused_res_hi;

  // A held result that the consumer has not taken freezes the whole pipeline.
  assign stall    = valid_q & ~out_ready_i;
  assign step     = in_tag_i.valid & ~stall;
  assign out_fire = valid_q & out_ready_i;

  assign res           = sat_add(wide_t'(acc_q), wide_t'(prod_i), AccW);
  assign clamped       = res.val[AccW-1:0];
  assign unused_res_hi = ^res.val[MaxW-1:AccW];

  // Next-state: accumulate, close a vector on its last element, retire on handshake.
  always_comb begin
    acc_d     = acc_q;
    sat_acc_d = sat_acc_q;
    f_d       = f_q;
    sat_d     = sat_q;
    valid_d   = valid_q;

    if (out_fire) begin
      valid_d = 1'b0;
    end

    if (step) begin
      if (in_tag_i.last) begin
        // Result leaves and the next vector restarts from zero with no bubble.
        f_d       = clamped;
        sat_d     = sat_acc_q | res.ovf;
        valid_d   = 1'b1;
        acc_d     = '0;
        sat_acc_d = 1'b0;
      end else begin
        acc_d     = clamped;
        sat_acc_d = sat_acc_q | res.ovf;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      sat_acc_q <= 1'b0;
      f_q       <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sat_acc_q <= sat_acc_d;
      f_q       <= f_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign f_o         = f_q;
  assign sat_o       = sat_q;
  assign stall_o     = stall;

endmodule

// File: rtl/mac_vec_sat.sv
// Pipelined saturating dot-product engine: operand stage, optional product stage,
// element counter, and a saturating accumulator with valid/ready on both sides.
module mac_vec_sat
  import mac_pkg::*;
#(
  parameter int unsigned IN_W      = 14,
  parameter int unsigned ACC_W     = 28,
  parameter int unsigned VEC_LEN   = 8,
  parameter int unsigned PIPE_MULT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    last_in,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic signed [ACC_W-1:0] f,
  output logic                    sat_out
);

  localparam int unsigned ProdW = 2 * IN_W;
  localparam int unsigned CntW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(VEC_LEN - 1);

  logic                    stall;
  logic                    accept;

  logic signed [IN_W-1:0]  a_q, a_d;
  logic signed [IN_W-1:0]  b_q, b_d;
  tag_t                    tag1_q, tag1_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic signed [ProdW-1:0] prod_s1;
  tag_t                    acc_tag;
  logic signed [ProdW-1:0] acc_prod;

  assign ready_in = ~stall;
  assign accept   = valid_in & ready_in;

  // Operand stage and element counter; the counter forces last on a full vector.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    tag1_d = tag1_q;
    cnt_d  = cnt_q;
    if (!stall) begin
      tag1_d.valid = accept;
      tag1_d.last  = last_in | (cnt_q == CntMax);
      if (accept) begin
        a_d   = a;
        b_d   = b;
        cnt_d = tag1_d.last ? '0 : cnt_q + CntW'(1);
      end
    end
  end

  // Operand/counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      tag1_q <= '0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      tag1_q <= tag1_d;
      cnt_q  <= cnt_d;
    end
  end

  // Full-width signed product; both operands are sign-extended before multiplying.
  assign prod_s1 = ProdW'(a_q) * ProdW'(b_q);

  if (PIPE_MULT != 0) begin : g_pipe
    logic signed [ProdW-1:0] prod_q, prod_d;
    tag_t                    tag2_q, tag2_d;

    // Product stage: follows stage 1 unless stalled; product only loads on valid.
    always_comb begin
      prod_d = prod_q;
      tag2_d = tag2_q;
      if (!stall) begin
        tag2_d = tag1_q;
        if (tag1_q.valid) begin
          prod_d = prod_s1;
        end
      end
    end

    // Product registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!reset) begin
        prod_q <= '0;
        tag2_q <= '0;
      end else begin
        prod_q <= prod_d;
        tag2_q <= tag2_d;
      end
    end

    assign acc_tag  = tag2_q;
    assign acc_prod = prod_q;
  end else begin : g_comb
    assign acc_tag  = tag1_q;
    assign acc_prod = prod_s1;
  end

  sat_accum #(
    .AccW  (ACC_W),
    .ProdW (ProdW)
  ) u_sat_accum (
    .clk_i       (clk),
    .rst_ni      (reset),
    .in_tag_i    (acc_tag),
    .prod_i      (acc_prod),
    .out_ready_i (ready_out),
    .out_valid_o (valid_out),
    .f_o         (f),
    .sat_o       (sat_out),
    .stall_o     (stall)
  );

endmodule

// File: tb/tb_mac_vec_sat.sv
// Scoreboard bench: drivers push expected results, monitors pop on each handshake.
module tb_mac_vec_sat;

  typedef struct {
    logic signed [27:0] f;
    logic               sat;
    int                 due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t q1[$];
  exp_t q2[$];

  // DUT 1: VEC_LEN=4, registered multiplier
  logic               valid1 = 1'b0, last1 = 1'b0, ready_out1 = 1'b1;
  logic signed [13:0] a1 = '0, b1 = '0;
  logic               ready_in1, valid_out1, sat1;
  logic signed [27:0] f1;

  // DUT 2: VEC_LEN=1, combinational multiplier
  logic               valid2 = 1'b0, last2 = 1'b0, ready_out2 = 1'b1;
  logic signed [13:0] a2 = '0, b2 = '0;
  logic               ready_in2, valid_out2, sat2;
  logic signed [27:0] f2;

  mac_vec_sat #(.IN_W(14), .ACC_W(28), .VEC_LEN(4), .PIPE_MULT(1)) dut1 (
    .clk(clk), .reset(rst_n), .valid_in(valid1), .ready_in(ready_in1), .last_in(last1),
    .a(a1), .b(b1), .valid_out(valid_out1), .ready_out(ready_out1), .f(f1), .sat_out(sat1)
  );

  mac_vec_sat #(.IN_W(14), .ACC_W(28), .VEC_LEN(1), .PIPE_MULT(0)) dut2 (
    .clk(clk), .reset(rst_n), .valid_in(valid2), .ready_in(ready_in2), .last_in(last2),
    .a(a2), .b(b2), .valid_out(valid_out2), .ready_out(ready_out2), .f(f2), .sat_out(sat2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  function automatic void push1(input longint fv, input logic s, input int due);
    exp_t e;
    e.f = 28'(fv); e.sat = s; e.due = due;
    q1.push_back(e);
  endfunction

  function automatic void push2(input longint fv, input logic s, input int due);
    exp_t e;
    e.f = 28'(fv); e.sat = s; e.due = due;
    q2.push_back(e);
  endfunction

  // Monitor for DUT 1
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (valid_out1 && ready_out1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected result: got f=%0d want no result", f1);
      end else begin
        e = q1.pop_front();
        chk("dut1 f", f1, e.f);
        chk("dut1 sat_out", sat1, e.sat);
        if (e.due >= 0) chk("dut1 latency cycle", cyc, e.due);
      end
    end
  end

  // Monitor for DUT 2
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (valid_out2 && ready_out2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2 unexpected result: got f=%0d want no result", f2);
      end else begin
        e = q2.pop_front();
        chk("dut2 f", f2, e.f);
        chk("dut2 sat_out", sat2, e.sat);
        if (e.due >= 0) chk("dut2 latency cycle", cyc, e.due);
      end
    end
  end

  // Present one element, wait for acceptance, return the negedge cycle before accept.
  task automatic send1(input int av, input int bv, input logic lst, output int c);
    int n;
    a1 = 14'(av); b1 = 14'(bv); last1 = lst; valid1 = 1'b1;
    #1;
    n = 0;
    while (!ready_in1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!ready_in1) begin
      total++; bad++;
      $display("FAIL dut1 accept timeout: ready_in=0 want 1");
    end
    c = cyc;
    @(negedge clk);
  endtask

  task automatic send2(input int av, input int bv, output int c);
    int n;
    a2 = 14'(av); b2 = 14'(bv); last2 = 1'b0; valid2 = 1'b1;
    #1;
    n = 0;
    while (!ready_in2 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!ready_in2) begin
      total++; bad++;
      $display("FAIL dut2 accept timeout: ready_in=0 want 1");
    end
    c = cyc;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " dut1 valid_out"}, valid_out1, 0);
    chk({tag, " dut1 f"}, f1, 0);
    chk({tag, " dut1 sat_out"}, sat1, 0);
    chk({tag, " dut2 valid_out"}, valid_out2, 0);
    chk({tag, " dut2 f"}, f2, 0);
  endtask

  initial begin
    int c;
    int n;
    bit pattern [11] = '{1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 1};

    // Reset
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset dut1 ready_in", ready_in1, 1);
    chk("post-reset dut2 ready_in", ready_in2, 1);

    // Basic vector, counter-terminated: 5+12+21+32
    send1(1, 5, 0, c); send1(2, 6, 0, c); send1(3, 7, 0, c); send1(4, 8, 0, c);
    push1(70, 1'b0, c + 3);

    // Positive saturation, then a clean vector that must clear the flag
    for (int i = 0; i < 4; i++) send1(8191, 8191, 0, c);
    push1(134217727, 1'b1, c + 3);
    for (int i = 0; i < 4; i++) send1(1, 1, 0, c);
    push1(4, 1'b0, c + 3);

    // Negative saturation
    for (int i = 0; i < 4; i++) send1(-8192, 8191, 0, c);
    push1(-134217728, 1'b1, c + 3);

    // Early termination, then a full vector proving the counter restarted
    send1(3, 3, 0, c); send1(3, 3, 1, c);
    push1(18, 1'b0, c + 3);
    send1(1, 5, 0, c); send1(2, 6, 0, c); send1(3, 7, 0, c); send1(4, 8, 0, c);
    push1(70, 1'b0, c + 3);
    valid1 = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure: result held, second vector blocked until release
    ready_out1 = 1'b0;
    for (int i = 0; i < 4; i++) send1(2, 2, 0, c);
    push1(16, 1'b0, -1);
    valid1 = 1'b0;
    n = 0;
    while (!valid_out1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("bp result valid", valid_out1, 1);
    a1 = 14'(1); b1 = 14'(5); last1 = 1'b0; valid1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp ready_in low", ready_in1, 0);
      chk("bp valid_out held", valid_out1, 1);
      chk("bp f held", f1, 16);
      @(negedge clk);
    end
    ready_out1 = 1'b1;
    send1(1, 5, 0, c); send1(2, 6, 0, c); send1(3, 7, 0, c); send1(4, 8, 0, c);
    push1(70, 1'b0, c + 3);
    valid1 = 1'b0;
    repeat (5) @(negedge clk);

    // Reset mid-vector discards the partial sum
    send1(9, 9, 0, c); send1(9, 9, 0, c);
    valid1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid reset dut1 ready_in", ready_in1, 1);
    send1(1, 5, 0, c); send1(2, 6, 0, c); send1(3, 7, 0, c); send1(4, 8, 0, c);
    push1(70, 1'b0, c + 3);
    valid1 = 1'b0;

    // DUT 2: every element is a vector, gaps must appear unchanged at the output
    for (int i = 0; i < 11; i++) begin
      if (pattern[i]) begin
        send2(-3, 7, c);
        push2(-21, 1'b0, c + 2);
      end else begin
        valid2 = 1'b0;
        @(negedge clk);
      end
    end
    send2(-8192, -8192, c);
    push2(67108864, 1'b0, c + 2);
    valid2 = 1'b0;

    // Drain
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 50) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk("dut1 results outstanding", q1.size(), 0);
    chk("dut2 results outstanding", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
